rca_64: RTL and testbench

//  64-bit unsigned ripple-carry adder with registered operands and registered results.

---
 rtl/full_adder.sv | 16 +
 rtl/rca_64.sv | 52 +++++
 tb/tb_rca_64.sv | 130 +++++++++++++
 3 files changed

// File: rtl/full_adder.sv
// One-bit full adder cell. Chained WIDTH times to form the ripple-carry adder in rca_64.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;

   assign p    = a ^ b;
   assign s    = p ^ cin;
   assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/rca_64.sv
// Pipelined ripple-carry adder: registered operands, pure full-adder chain, registered result.
// This is the baseline against which the faster adder variants are compared.
module rca_64 #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic [WIDTH-1:0] sum,
   output logic             crout
);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] s;
   logic [WIDTH:0]   c;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         a_q <= op1;
         b_q <= op2;
      end
   end

   assign c[0] = 1'b0;

   // Deliberately no lookahead: the carry ripples through every cell.
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      full_adder u_fa (
         .a    (a_q[i]),
         .b    (b_q[i]),
         .cin  (c[i]),
         .s    (s[i]),
         .cout (c[i+1])
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sum   <= '0;
         crout <= 1'b0;
      end else begin
         sum   <= s;
         crout <= c[WIDTH];
      end
   end

endmodule

// File: tb/tb_rca_64.sv
// Directed bench for rca_64: table of hand-computed sums, reset corner cases, back-to-back issue.
module tb_rca_64;

   localparam int unsigned WIDTH = 64;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] s;
      logic             c;
   } vec_t;

   logic             clock;
   logic             reset;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] op2;
   logic [WIDTH-1:0] sum;
   logic             crout;

   int n_vec;
   int n_err;

   vec_t vecs[8];

   rca_64 #(
      .WIDTH (WIDTH)
   ) dut (
      .clock (clock),
      .reset (reset),
      .op1   (op1),
      .op2   (op2),
      .sum   (sum),
      .crout (crout)
   );

   initial clock = 1'b0;
   always #12 clock = ~clock;

   task automatic check(input string name, input logic [WIDTH-1:0] exp_s, input logic exp_c);
      n_vec++;
      if (sum !== exp_s || crout !== exp_c) begin
         n_err++;
         $display("FAIL %s: got sum=%h crout=%b, want sum=%h crout=%b",
                  name, sum, crout, exp_s, exp_c);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;

      vecs[0] = '{64'h00000000_12345678, 64'h00000000_90ABCDEF, 64'h00000000_A2E02467, 1'b0};
      vecs[1] = '{64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000001, 64'h00000000_00000000, 1'b1};
      vecs[2] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFE, 1'b1};
      vecs[3] = '{64'hAAAAAAAA_AAAAAAAA, 64'h55555555_55555555, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
      vecs[4] = '{64'h00000000_00000001, 64'h00000000_00000001, 64'h00000000_00000002, 1'b0};
      vecs[5] = '{64'h80000000_00000000, 64'h80000000_00000000, 64'h00000000_00000000, 1'b1};
      vecs[6] = '{64'h00000000_FFFFFFFF, 64'h00000000_00000001, 64'h00000001_00000000, 1'b0};
      vecs[7] = '{64'h7FFFFFFF_FFFFFFFF, 64'h00000000_00000001, 64'h80000000_00000000, 1'b0};

      // Reset held across clock edges, then released with zero operands.
      reset = 1'b0;
      op1   = '0;
      op2   = '0;
      #3;
      check("reset_async", '0, 1'b0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_held", '0, 1'b0);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("after_release", '0, 1'b0);

      // One vector at a time, sampled two rising edges after it is applied.
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         op1 = vecs[i].a;
         op2 = vecs[i].b;
         @(posedge clock);
         @(posedge clock);
         @(negedge clock);
         check($sformatf("vec%0d", i), vecs[i].s, vecs[i].c);
      end

      // Mid-operation reset: nonzero result visible and another sum in flight.
      @(negedge clock);
      op1 = vecs[3].a;
      op2 = vecs[3].b;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("pre_reset", vecs[3].s, vecs[3].c);
      op1 = vecs[2].a;
      op2 = vecs[2].b;
      @(posedge clock);
      #5 reset = 1'b0;
      #1;
      check("mid_reset_immediate", '0, 1'b0);
      @(posedge clock);
      @(negedge clock);
      check("mid_reset_held", '0, 1'b0);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("release_edge1", '0, 1'b0);
      @(posedge clock);
      @(negedge clock);
      check("release_edge2", vecs[2].s, vecs[2].c);

      // Back-to-back issue: one new operand pair per cycle, one result per cycle.
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (i >= 2) check($sformatf("b2b%0d", i - 2), vecs[i - 2].s, vecs[i - 2].c);
         if (i < 8) begin
            op1 = vecs[i].a;
            op2 = vecs[i].b;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
